inst_fetch_ctrl: RTL

Sequences instruction fetch between the PC stage and the SRAM-like instruction bus (cache or uncached bridge). Takes the current fetch address, cached attribute and read-enable from the PC stage. Issues one bus read at a time with req/addr_ok/data_ok handshakes and delivers the instruction with its PC to decode. Generates the fetch stall the PC stage consumes, and cancels in-flight fetches on branch/exception redirect without violating bus rules.

---
 rtl/inst_fetch_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer between the PC stage and an SRAM-like instruction bus.
// Keeps at most one read outstanding and lets redirects retire in-flight reads quietly.
module inst_fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        fetch_en_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_cached_i,
  input  logic        redirect_i,
  input  logic        id_stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_cached_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        exc_adel_o,
  output logic        exc_buserr_o,
  output logic        fetch_stall_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    HOLD      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              cached_q, cached_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              adel_q, adel_d;
  logic              buserr_q, buserr_d;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_s;

  // A read whose data is still owed is dropped if any redirect has hit it, including this cycle's.
  assign kill_s = discard_q | redirect_i;

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    cached_d  = cached_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    adel_d    = adel_q;
    buserr_d  = buserr_q;
    discard_d = discard_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (fetch_en_i && !redirect_i) begin
          if (fetch_pc_i[1:0] == 2'b00) begin
            req_d    = 1'b1;
            addr_d   = {fetch_pc_i[31:2], 2'b00};
            cached_d = fetch_cached_i;
            pc_d     = fetch_pc_i;
            state_d  = REQ;
          end else begin
            valid_d   = 1'b1;
            inst_d    = 32'h0000_0000;
            inst_pc_d = fetch_pc_i;
            adel_d    = 1'b1;
            buserr_d  = 1'b0;
            state_d   = HOLD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // The request stays up until accepted; a redirect only marks the read for discard.
        if (redirect_i) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (inst_addr_ok_i) begin
          req_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = WAIT_DATA;
        end else begin
          req_d = 1'b1;
        end
      end
      WAIT_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (inst_data_ok_i || (cnt_q == TIMEOUT_LAST)) begin
          if (kill_s) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            valid_d   = 1'b1;
            inst_d    = inst_data_ok_i ? inst_rdata_i : 32'h0000_0000;
            inst_pc_d = pc_q;
            adel_d    = 1'b0;
            buserr_d  = ~inst_data_ok_i;
            state_d   = HOLD;
          end
        end else begin
          discard_d = kill_s;
        end
      end
      HOLD: begin
        if (redirect_i || !id_stall_i) begin
          valid_d  = 1'b0;
          adel_d   = 1'b0;
          buserr_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= 32'h0000_0000;
      cached_q  <= 1'b0;
      pc_q      <= 32'h0000_0000;
      valid_q   <= 1'b0;
      inst_q    <= 32'h0000_0000;
      inst_pc_q <= 32'h0000_0000;
      adel_q    <= 1'b0;
      buserr_q  <= 1'b0;
      discard_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      cached_q  <= cached_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      adel_q    <= adel_d;
      buserr_q  <= buserr_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
    end
  end

  assign inst_req_o    = req_q;
  assign inst_addr_o   = addr_q;
  assign inst_cached_o = cached_q;
  assign inst_valid_o  = valid_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign exc_adel_o    = adel_q;
  assign exc_buserr_o  = buserr_q;
  assign fetch_stall_o = reset_i & ((state_q == REQ) | (state_q == WAIT_DATA) |
                                    ((state_q == HOLD) & id_stall_i));

endmodule
